// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and default sizes for the button conditioner
package btn_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } btn_state_t;

  localparam int DEF_CNT_W  = 20;
  localparam int DEF_LONG_W = 28;
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/btn_deb_chan.sv
// rtl/btn_deb_chan.sv - one channel: synchroniser, debounce FSM, long-press timer
// BTN_REPEAT_EN adds the auto-repeat counter; otherwise btn_repeat is tied low.
module btn_deb_chan import btn_pkg::*; #(
  parameter int               CNT_W          = DEF_CNT_W,
  parameter logic [CNT_W-1:0] BTN_DELAY      = 20'h7_ffff,
  parameter bit               BTN_ACTIVE_LOW = 1'b1,
  parameter int               LONG_W         = DEF_LONG_W,
  parameter logic [LONG_W-1:0] LONG_DELAY    = 28'd50_000_000,
  parameter logic [LONG_W-1:0] REPEAT_DELAY  = 28'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_deb,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam logic [LONG_W-1:0] LONG_LAST = LONG_DELAY - 1'b1;

  logic                  raw;
  logic [SYNC_DEPTH-1:0] sync;
  logic                  s;
  btn_state_t            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [LONG_W-1:0]     lcnt, lcnt_n;
  logic                  deb_n, press_n, rel_n, long_n;

  assign raw = BTN_ACTIVE_LOW ? ~btn_in : btn_in;
  assign s   = sync[SYNC_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= '0;
      state       <= REL;
      cnt         <= '0;
      lcnt        <= '0;
      btn_deb     <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_DEPTH-2:0], raw};
      state       <= state_n;
      cnt         <= cnt_n;
      lcnt        <= lcnt_n;
      btn_deb     <= deb_n;
      btn_press   <= press_n;
      btn_release <= rel_n;
      btn_long    <= long_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lcnt_n  = lcnt;
    deb_n   = btn_deb;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    case (state)
      REL: begin
        if (s) begin
          state_n = CHK_P;
          cnt_n   = '0;
        end
      end
      CHK_P: begin
        if (!s) begin
          state_n = REL;
          cnt_n   = '0;
        end else if (cnt == BTN_DELAY) begin
          state_n = PRS;
          cnt_n   = '0;
          lcnt_n  = '0;
          deb_n   = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRS: begin
        // lcnt parks at LONG_DELAY so the long pulse cannot recur within one press
        if (lcnt != LONG_DELAY) lcnt_n = lcnt + 1'b1;
        if (lcnt == LONG_LAST) long_n = 1'b1;
        if (!s) begin
          state_n = CHK_R;
          cnt_n   = '0;
        end
      end
      CHK_R: begin
        if (s) begin
          state_n = PRS;
          cnt_n   = '0;
        end else if (cnt == BTN_DELAY) begin
          state_n = REL;
          cnt_n   = '0;
          lcnt_n  = '0;
          deb_n   = 1'b0;
          rel_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = REL;
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam logic [LONG_W-1:0] RPT_LAST = REPEAT_DELAY - 1'b1;
  logic [LONG_W-1:0] rcnt;

  // Counts only while held in PRS after the long pulse; any release check restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt       <= '0;
      btn_repeat <= 1'b0;
    end else begin
      btn_repeat <= 1'b0;
      if (state != PRS) begin
        rcnt <= '0;
      end else if (lcnt == LONG_DELAY) begin
        if (rcnt == RPT_LAST) begin
          rcnt       <= '0;
          btn_repeat <= 1'b1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_DELAY;
  assign btn_repeat    = 1'b0;
`endif

endmodule

// File: rtl/btn_deb_ctrl.sv
// rtl/btn_deb_ctrl.sv - multi-channel button conditioner top
// BTN_REPEAT_EN enables auto-repeat pulses on btn_repeat.
module btn_deb_ctrl import btn_pkg::*; #(
  parameter int                BTN_WIDTH      = 8,
  parameter int                CNT_W          = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  BTN_DELAY      = 20'h7_ffff,
  parameter bit                BTN_ACTIVE_LOW = 1'b1,
  parameter int                LONG_W         = DEF_LONG_W,
  parameter logic [LONG_W-1:0] LONG_DELAY     = 28'd50_000_000,
  parameter logic [LONG_W-1:0] REPEAT_DELAY   = 28'd10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [BTN_WIDTH-1:0] btn_deb,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic [BTN_WIDTH-1:0] btn_long,
  output logic [BTN_WIDTH-1:0] btn_repeat
);

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_chan
    btn_deb_chan #(
      .CNT_W         (CNT_W),
      .BTN_DELAY     (BTN_DELAY),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW),
      .LONG_W        (LONG_W),
      .LONG_DELAY    (LONG_DELAY),
      .REPEAT_DELAY  (REPEAT_DELAY)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in[i]),
      .btn_deb    (btn_deb[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_long   (btn_long[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_deb_ctrl.sv
// tb/tb_btn_deb_ctrl.sv - scoreboard bench for btn_deb_ctrl (BTN_REPEAT_EN aware)
module tb_btn_deb_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
    logic [3:0] rp;
    logic [3:0] deb;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = 4'hF;
  logic [3:0] btn_deb, btn_press, btn_release, btn_long, btn_repeat;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_deb = 4'h0;
  ev_t  q[$];

  btn_deb_ctrl #(
    .BTN_WIDTH     (4),
    .CNT_W         (20),
    .BTN_DELAY     (20'd15),
    .BTN_ACTIVE_LOW(1'b1),
    .LONG_W        (28),
    .LONG_DELAY    (28'd100),
    .REPEAT_DELAY  (28'd20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_deb    (btn_deb),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] rp);
    ev_t e;
    exp_deb = (exp_deb | p) & ~r;
    e.cyc = c; e.p = p; e.r = r; e.l = l; e.rp = rp; e.deb = exp_deb;
    q.push_back(e);
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest expected event; overdue events are misses.
  always @(negedge clk) begin
    logic [15:0] pulses;
    ev_t e;
    pulses = {btn_press, btn_release, btn_long, btn_repeat};
    if (!rst) begin
      if (pulses != 16'h0) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", int'(pulses), 0);
        end else if (q[0].cyc > cyc) begin
          chk("early_event", cyc, q[0].cyc);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_pulses", int'(pulses), int'({e.p, e.r, e.l, e.rp}));
          chk("event_deb", int'(btn_deb), int'(e.deb));
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missing_event", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    wait_neg(3);
    chk("reset_deb", int'(btn_deb), 0);
    chk("reset_press", int'(btn_press), 0);
    chk("reset_release", int'(btn_release), 0);
    chk("reset_long", int'(btn_long), 0);
    chk("reset_repeat", int'(btn_repeat), 0);
    rst = 1'b0;
    wait_neg(5);

    // Clean press on channel 0, 50 cycles
    n = cyc;
    push(n + 19, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(n + 69, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    btn_in[0] = 1'b0;
    wait_neg(50);
    btn_in[0] = 1'b1;
    wait_neg(40);

    // Bounce on channel 1, then settle pressed at n+60
    n = cyc;
    push(n + 79, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push(n + 119, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    for (int j = 0; j < 12; j++) begin
      btn_in[1] = j[0];
      wait_neg(5);
    end
    btn_in[1] = 1'b0;
    wait_neg(40);
    btn_in[1] = 1'b1;
    wait_neg(40);

    // Long press on channel 2, 300 cycles
    n = cyc;
    push(n + 19, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push(n + 119, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
`ifdef BTN_REPEAT_EN
    for (int k = 1; k <= 9; k++) push(n + 119 + 20 * k, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
`endif
    push(n + 319, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    btn_in[2] = 1'b0;
    wait_neg(300);
    btn_in[2] = 1'b1;
    wait_neg(40);

    // Release bounce 60 cycles into a press on channel 0: long shifts by 5
    n = cyc;
    push(n + 19, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(n + 124, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
`ifdef BTN_REPEAT_EN
    for (int k = 1; k <= 3; k++) push(n + 124 + 20 * k, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
`endif
    push(n + 219, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    btn_in[0] = 1'b0;
    wait_neg(79);
    btn_in[0] = 1'b1;
    wait_neg(5);
    btn_in[0] = 1'b0;
    wait_neg(116);
    btn_in[0] = 1'b1;
    wait_neg(40);

    // Reset while channel 3 is in CHK_P and channel 2 is pressed
    n = cyc;
    push(n + 19, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    btn_in[2] = 1'b0;
    wait_neg(25);
    n = cyc;
    btn_in[3] = 1'b0;
    wait_neg(6);
    rst = 1'b1;
    wait_neg(1);
    chk("midreset_deb", int'(btn_deb), 0);
    chk("midreset_pulses", int'({btn_press, btn_release, btn_long, btn_repeat}), 0);
    rst = 1'b0;
    exp_deb = 4'h0;
    push(n + 26, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    wait_neg(40);
    n = cyc;
    push(n + 19, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
    btn_in[2] = 1'b1;
    btn_in[3] = 1'b1;
    wait_neg(40);

    // Concurrent press on channels 0 and 3
    n = cyc;
    push(n + 19, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    push(n + 49, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    btn_in[0] = 1'b0;
    btn_in[3] = 1'b0;
    wait_neg(30);
    btn_in[0] = 1'b1;
    btn_in[3] = 1'b1;
    wait_neg(40);

    chk("final_deb", int'(btn_deb), 0);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
